// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_pkg
// Shared definitions for the fetch-stage branch predictor: datapath width,
// the 2-bit saturating counter encodings and the saturating step helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package branch_predictor_pkg;

    localparam int XLEN = 32;

    // 2-bit branch history counter; bit 1 is the taken/not-taken prediction
    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } ctrState_e;

    // Step towards strong-taken, holding at the ceiling
    function automatic logic [1:0] sat_inc2(input logic [1:0] ctr);
        sat_inc2 = (ctr == CTR_STRONG_T) ? CTR_STRONG_T : ctr + 2'b01;
    endfunction

    // Step towards strong-not-taken, holding at the floor
    function automatic logic [1:0] sat_dec2(input logic [1:0] ctr);
        sat_dec2 = (ctr == CTR_STRONG_NT) ? CTR_STRONG_NT : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_if
// Bundles the fetch lookup, decode resolution, redirect and statistics
// signals between the core (master) and the branch predictor (slave).
//   pcF / pred_takenF / pred_targF           : fetch-stage lookup
//   stall, res_*                             : decode-stage resolution
//   mispredict / redirect_pc                 : fetch redirect
//   br_count / mp_count                      : CSR/debug statistics
// ---------------------------------------------------------------------------
interface branch_predictor_if
    import branch_predictor_pkg::*;
#(
    parameter int W = XLEN
);
    logic [W-1:0] pcF;
    logic         pred_takenF;
    logic [W-1:0] pred_targF;
    logic         stall;
    logic         res_valid;
    logic [W-1:0] res_pc;
    logic         res_taken;
    logic [W-1:0] res_targ;
    logic         res_pred_taken;
    logic [W-1:0] res_pred_targ;
    logic         mispredict;
    logic [W-1:0] redirect_pc;
    logic [31:0]  br_count;
    logic [31:0]  mp_count;

    modport master (
        output pcF, stall, res_valid, res_pc, res_taken, res_targ,
               res_pred_taken, res_pred_targ,
        input  pred_takenF, pred_targF, mispredict, redirect_pc,
               br_count, mp_count
    );

    modport slave (
        input  pcF, stall, res_valid, res_pc, res_taken, res_targ,
               res_pred_taken, res_pred_targ,
        output pred_takenF, pred_targF, mispredict, redirect_pc,
               br_count, mp_count
    );

endinterface

// File: rtl/branch_predictor_bp_table.sv
// ---------------------------------------------------------------------------
// bp_table
// Direct-mapped predictor table: per entry a valid bit, tag, branch target
// and 2-bit counter. Two combinational read ports (fetch lookup, and the
// resolving branch so the update logic can see the current entry) and one
// write port. Writes always set valid.
//   clk, rst_n                  : clock, async active-low reset
//   lkIdx_i  -> lk*_o           : fetch lookup read port
//   upIdx_i  -> up*_o           : update-side read port
//   we_i, upIdx_i, wr*_i        : write port (shares the update index)
// ---------------------------------------------------------------------------
module bp_table #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] lkIdx_i,
    output logic             lkValid_o,
    output logic [TAG_W-1:0] lkTag_o,
    output logic [XLEN-1:0]  lkTarg_o,
    output logic [1:0]       lkCtr_o,
    input  logic [IDX_W-1:0] upIdx_i,
    output logic             upValid_o,
    output logic [TAG_W-1:0] upTag_o,
    output logic [XLEN-1:0]  upTarg_o,
    output logic [1:0]       upCtr_o,
    input  logic             we_i,
    input  logic [TAG_W-1:0] wrTag_i,
    input  logic [XLEN-1:0]  wrTarg_i,
    input  logic [1:0]       wrCtr_i
);

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0]  targ_q  [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];

    // Reads see the stored contents only; a same-cycle write is not bypassed
    assign lkValid_o = valid_q[lkIdx_i];
    assign lkTag_o   = tag_q[lkIdx_i];
    assign lkTarg_o  = targ_q[lkIdx_i];
    assign lkCtr_o   = ctr_q[lkIdx_i];

    assign upValid_o = valid_q[upIdx_i];
    assign upTag_o   = tag_q[upIdx_i];
    assign upTarg_o  = targ_q[upIdx_i];
    assign upCtr_o   = ctr_q[upIdx_i];

    // Entry storage: reset leaves every counter weak-not-taken so a freshly
    // allocated branch only needs one resolve to move either way
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                targ_q[i]  <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (we_i) begin
            valid_q[upIdx_i] <= 1'b1;
            tag_q[upIdx_i]   <= wrTag_i;
            targ_q[upIdx_i]  <= wrTarg_i;
            ctr_q[upIdx_i]   <= wrCtr_i;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Fetch-stage predictor and redirect controller. Looks up pcF in the table
// to produce the predicted next PC, compares the decode-stage resolution
// against the prediction carried with the instruction, raises a one-cycle
// mispredict with the correct redirect PC, trains the table, and keeps
// saturating branch / mispredict statistics.
//   clk    : core clock, rising edge
//   rst_n  : asynchronous active-low reset (deassert synchronised here)
//   bus    : branch_predictor_if slave modport (lookup, resolve, redirect,
//            statistics)
// ---------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_predictor_if.slave   bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [1:0]       rstSync_q;
    logic             rstInt_n;

    logic             lkValid;
    logic [TAG_W-1:0] lkTag;
    logic [XLEN-1:0]  lkTarg;
    logic [1:0]       lkCtr;
    logic             hitF;

    logic             upValid;
    logic [TAG_W-1:0] upTag;
    logic [XLEN-1:0]  upTarg;
    logic [1:0]       upCtr;
    logic             upHit;
    logic             upd;
    logic             mispredictInt;

    logic             we;
    logic [XLEN-1:0]  wrTarg;
    logic [1:0]       wrCtr;

    logic [31:0]      brCount_q, brCount_d;
    logic [31:0]      mpCount_q, mpCount_d;

    logic             unusedBits;

    // Reset assertion takes effect immediately; release is retimed to clk so
    // the table and counters leave reset on a clean edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstInt_n = rstSync_q[1];

    bp_table #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) uTable (
        .clk       (clk),
        .rst_n     (rstInt_n),
        .lkIdx_i   (bus.pcF[IDX_W+1:2]),
        .lkValid_o (lkValid),
        .lkTag_o   (lkTag),
        .lkTarg_o  (lkTarg),
        .lkCtr_o   (lkCtr),
        .upIdx_i   (bus.res_pc[IDX_W+1:2]),
        .upValid_o (upValid),
        .upTag_o   (upTag),
        .upTarg_o  (upTarg),
        .upCtr_o   (upCtr),
        .we_i      (we),
        .wrTag_i   (bus.res_pc[XLEN-1:IDX_W+2]),
        .wrTarg_i  (wrTarg),
        .wrCtr_i   (wrCtr)
    );

    // Fetch lookup: target is exposed on any tag hit, direction from ctr[1]
    assign hitF             = lkValid && (lkTag == bus.pcF[XLEN-1:IDX_W+2]);
    assign bus.pred_takenF  = hitF && lkCtr[1];
    assign bus.pred_targF   = hitF ? lkTarg : '0;

    // Resolution compare; a wrong target only matters when the branch is taken
    assign upd           = bus.res_valid && !bus.stall;
    assign mispredictInt = upd &&
                           ((bus.res_taken != bus.res_pred_taken) ||
                            (bus.res_taken && (bus.res_targ != bus.res_pred_targ)));
    assign bus.mispredict  = mispredictInt;
    assign bus.redirect_pc = bus.res_taken ? bus.res_targ : bus.res_pc + XLEN'(4);

    // Training: a hit steps the counter, a taken miss allocates weak-taken,
    // a not-taken miss leaves the (possibly aliased) entry alone
    assign upHit  = upValid && (upTag == bus.res_pc[XLEN-1:IDX_W+2]);
    assign we     = upd && (upHit || bus.res_taken);
    assign wrTarg = bus.res_taken ? bus.res_targ : upTarg;

    always_comb begin
        wrCtr = CTR_WEAK_T;
        if (upHit) begin
            wrCtr = bus.res_taken ? sat_inc2(upCtr) : sat_dec2(upCtr);
        end
    end

    // Statistics counters stick at all-ones instead of wrapping
    always_comb begin
        brCount_d = brCount_q;
        mpCount_d = mpCount_q;
        if (upd && (brCount_q != 32'hFFFF_FFFF)) begin
            brCount_d = brCount_q + 32'd1;
        end
        if (mispredictInt && (mpCount_q != 32'hFFFF_FFFF)) begin
            mpCount_d = mpCount_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            brCount_q <= '0;
            mpCount_q <= '0;
        end else begin
            brCount_q <= brCount_d;
            mpCount_q <= mpCount_d;
        end
    end

    assign bus.br_count = brCount_q;
    assign bus.mp_count = mpCount_q;

    // Byte-offset bits and the weak/strong half of the fetch counter are
    // never needed
    assign unusedBits = ^{bus.pcF[1:0], bus.res_pc[1:0], lkCtr[0]};

endmodule
